a2d_scan_ctrl: RTL and testbench

A2D_SCAN_CTRL -- requirements
Module: a2d_scan_ctrl

---
 rtl/a2d_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_a2d_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : a2d_scan_ctrl                                              |
// | Description : Multi-channel A2D scan controller. For each enabled        |
// |               channel it runs a CMD frame and a READ frame over SPI,     |
// |               stores the returned sample and exposes the results         |
// |               through a combinational read port.                        |
// | Options     : A2D_AVG_EN - store a running average instead of the raw    |
// |               sample (first sample after reset is stored as-is).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module a2d_scan_ctrl #(
  parameter int NUM_CHNNL = 8,
  parameter int RES_W     = 12,
  parameter int SCLK_DIV  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt_cnv,
  input  logic                 cont,
  input  logic [NUM_CHNNL-1:0] chnl_mask,
  input  logic [2:0]           rd_chnl,
  output logic [RES_W-1:0]     rd_data,
  output logic                 cnv_cmplt,
  output logic                 busy,
  output logic                 a2d_SS_n,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);

  // A frame is 34 half-periods: one lead-in, 32 for the 16 bits, one tail.
  localparam int         HALF    = SCLK_DIV / 2;
  localparam int         DIV_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [5:0] LAST_HP = 6'd33;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    STORE = 3'd4,
    NEXT  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [5:0]           hp_q, hp_d;
  logic                 gap_q, gap_d;
  logic [2:0]           chnl_q, chnl_d;
  logic [NUM_CHNNL-1:0] mask_q, mask_d;
  logic [RES_W-1:0]     shift_q, shift_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ss_n_q, ss_n_d;
  logic                 cmplt_q, cmplt_d;
  logic [RES_W-1:0]     res_q [NUM_CHNNL];

  logic [15:0]          w_word;
  logic [5:0]           w_hp_nx;
  logic                 w_frame_done;
  logic                 w_lo_found, w_nx_found;
  logic [2:0]           w_lo_idx, w_nx_idx;
  logic [RES_W-1:0]     w_store;

  assign w_word  = {2'b00, chnl_q, 11'h000};
  assign w_hp_nx = hp_q + 6'd1;

  // Lowest enabled channel of the live mask, and next enabled channel above the current one.
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = 3'd0;
    w_nx_found = 1'b0;
    w_nx_idx   = 3'd0;
    for (int i = NUM_CHNNL - 1; i >= 0; i--) begin
      if (chnl_mask[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = 3'(i);
      end
      if (mask_q[i] && (3'(i) > chnl_q)) begin
        w_nx_found = 1'b1;
        w_nx_idx   = 3'(i);
      end
    end
  end

  // Next-state logic: SPI frame engine plus scan sequencing.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    hp_d         = hp_q;
    gap_d        = gap_q;
    chnl_d       = chnl_q;
    mask_d       = mask_q;
    shift_d      = shift_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    ss_n_d       = ss_n_q;
    cmplt_d      = 1'b0;
    w_frame_done = 1'b0;

    if ((state_q == CMD) || (state_q == READ)) begin
      if (div_q == DIV_W'(HALF - 1)) begin
        div_d = '0;
        if (hp_q == LAST_HP) begin
          w_frame_done = 1'b1;
          ss_n_d       = 1'b1;
        end else begin
          hp_d = w_hp_nx;
          if (w_hp_nx[0] && (w_hp_nx <= 6'd31)) begin
            // falling edge: present next bit, MSB first
            sclk_d = 1'b0;
            mosi_d = w_word[4'd15 - w_hp_nx[4:1]];
          end else if (!w_hp_nx[0] && (w_hp_nx <= 6'd32)) begin
            // rising edge: sample MISO; only the last RES_W bits survive
            sclk_d  = 1'b1;
            shift_d = RES_W'({shift_q, MISO});
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (strt_cnv) begin
          if (w_lo_found) begin
            mask_d  = chnl_mask;
            chnl_d  = w_lo_idx;
            state_d = CMD;
            ss_n_d  = 1'b0;
            div_d   = '0;
            hp_d    = '0;
            sclk_d  = 1'b1;
          end else begin
            cmplt_d = 1'b1;
          end
        end
      end
      CMD: begin
        if (w_frame_done) begin
          state_d = GAP;
          gap_d   = 1'b0;
        end
      end
      GAP: begin
        if (gap_q) begin
          state_d = READ;
          ss_n_d  = 1'b0;
          div_d   = '0;
          hp_d    = '0;
          sclk_d  = 1'b1;
        end else begin
          gap_d = 1'b1;
        end
      end
      READ: begin
        if (w_frame_done) begin
          state_d = STORE;
        end
      end
      STORE: begin
        state_d = NEXT;
      end
      NEXT: begin
        if (w_nx_found) begin
          chnl_d  = w_nx_idx;
          state_d = CMD;
          ss_n_d  = 1'b0;
          div_d   = '0;
          hp_d    = '0;
          sclk_d  = 1'b1;
        end else begin
          cmplt_d = 1'b1;
          if (cont && w_lo_found) begin
            mask_d  = chnl_mask;
            chnl_d  = w_lo_idx;
            state_d = CMD;
            ss_n_d  = 1'b0;
            div_d   = '0;
            hp_d    = '0;
            sclk_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and SPI output registers; reset aborts any frame with SS_n high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      gap_q   <= 1'b0;
      chnl_q  <= 3'd0;
      mask_q  <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      cmplt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      gap_q   <= gap_d;
      chnl_q  <= chnl_d;
      mask_q  <= mask_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      cmplt_q <= cmplt_d;
    end
  end

`ifdef A2D_AVG_EN
  logic [NUM_CHNNL-1:0] seen_q;
  logic [RES_W+1:0]     w_avg;

  // new = (old*3 + sample + 2) >> 2 in RES_W+2 bits; cannot overflow.
  assign w_avg   = (({2'b00, res_q[chnl_q]} * (RES_W+2)'(3)) + {2'b00, shift_q} + (RES_W+2)'(2)) >> 2;
  assign w_store = seen_q[chnl_q] ? w_avg[RES_W-1:0] : shift_q;

  // Per-channel flag so the first sample after reset is stored unaveraged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
    end else if (state_q == STORE) begin
      seen_q[chnl_q] <= 1'b1;
    end
  end
`else
  assign w_store = shift_q;
`endif

  // Result registers, written in STORE only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHNNL; i++) begin
        res_q[i] <= '0;
      end
    end else if (state_q == STORE) begin
      res_q[chnl_q] <= w_store;
    end
  end

  assign rd_data   = (int'(rd_chnl) < NUM_CHNNL) ? res_q[rd_chnl] : '0;
  assign busy      = (state_q != IDLE);
  assign cnv_cmplt = cmplt_q;
  assign a2d_SS_n  = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_a2d_scan_ctrl                                           |
// | Description : Self-checking bench for a2d_scan_ctrl with an SPI ADC      |
// |               slave model and a behavioural result model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_a2d_scan_ctrl;

  localparam int NUM_CHNNL  = 8;
  localparam int RES_W      = 12;
  localparam int SCLK_DIV   = 32;
  localparam int FRAME_CLKS = 17 * SCLK_DIV;
`ifdef A2D_AVG_EN
  localparam logic [11:0] AVG_SECOND = 12'h500;
`else
  localparam logic [11:0] AVG_SECOND = 12'h800;
`endif

  logic             clk = 1'b0;
  logic             rst, strt_cnv, cont, MISO;
  logic [7:0]       chnl_mask;
  logic [2:0]       rd_chnl;
  logic [RES_W-1:0] rd_data;
  logic             cnv_cmplt, busy, a2d_SS_n, SCLK, MOSI;

  always #5 clk = ~clk;

  a2d_scan_ctrl #(.NUM_CHNNL(NUM_CHNNL), .RES_W(RES_W), .SCLK_DIV(SCLK_DIV)) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .cont(cont), .chnl_mask(chnl_mask),
    .rd_chnl(rd_chnl), .rd_data(rd_data), .cnv_cmplt(cnv_cmplt), .busy(busy),
    .a2d_SS_n(a2d_SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  int checks = 0;
  int failures = 0;

  // ADC slave model and bus monitor state
  logic [RES_W-1:0] adc_val [NUM_CHNNL];
  logic [15:0]      frames[$];
  int               low_lens[$], fall_list[$], gaps[$];
  int               cmplt_cnt = 0;
  logic             prev_ss, prev_sclk, is_read, had_frame;
  int               bitcnt, fall_cnt, low_len, high_len, cur_gap;
  logic [15:0]      rxw, txw;
  logic [2:0]       cmd_ch;

  // Reference model of stored results
  logic [RES_W-1:0] exp_res [NUM_CHNNL];
  bit               seen [NUM_CHNNL];

  // Slave: drive MISO on SCLK fall, capture MOSI on SCLK rise; log frame shape.
  always @(negedge clk) begin
    if (rst) begin
      prev_ss = 1'b1; prev_sclk = 1'b1; is_read = 1'b0; had_frame = 1'b0;
      MISO = 1'b0; low_len = 0; high_len = 0; bitcnt = 0; fall_cnt = 0; cmd_ch = 3'd0;
    end else begin
      if (prev_ss && !a2d_SS_n) begin
        cur_gap = had_frame ? high_len : -1;
        bitcnt = 0; fall_cnt = 0; low_len = 0; rxw = 16'h0;
        txw = is_read ? {4'($urandom), adc_val[cmd_ch]} : 16'($urandom);
      end
      if (!prev_ss && a2d_SS_n) begin
        frames.push_back(rxw); low_lens.push_back(low_len);
        fall_list.push_back(fall_cnt); gaps.push_back(cur_gap);
        if (!is_read) cmd_ch = rxw[13:11];
        is_read = !is_read; had_frame = 1'b1; high_len = 0;
      end
      if (!a2d_SS_n) begin
        low_len++;
        if (prev_sclk && !SCLK) begin MISO = txw[15 - bitcnt]; fall_cnt++; end
        if (!prev_sclk && SCLK) begin rxw = {rxw[14:0], MOSI}; bitcnt++; end
      end else begin
        high_len++;
      end
      if (cnv_cmplt) cmplt_cnt++;
      prev_ss = a2d_SS_n; prev_sclk = SCLK;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CHNNL; c++) begin exp_res[c] = '0; seen[c] = 1'b0; end
  endfunction

  function automatic void model_store(input int ch, input logic [RES_W-1:0] s);
`ifdef A2D_AVG_EN
    if (seen[ch]) exp_res[ch] = RES_W'((int'(exp_res[ch]) * 3 + int'(s) + 2) / 4);
    else exp_res[ch] = s;
`else
    exp_res[ch] = s;
`endif
    seen[ch] = 1'b1;
  endfunction

  task automatic wait_cmplt(input int target, input int budget, input string tag);
    int n = 0;
    while ((cmplt_cnt < target) && (n < budget)) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 32'(cmplt_cnt >= target), 32'd1);
  endtask

  task automatic check_rd_all(input string tag);
    for (int c = 0; c < NUM_CHNNL; c++) begin
      rd_chnl = 3'(c);
      #1;
      chk(tag, 32'(rd_data), 32'(exp_res[c]));
    end
  endtask

  // One single pass over mask m; frames, timing, completion and results are checked.
  task automatic do_pass(input logic [7:0] m, input string tag);
    int fbase = frames.size();
    int cbase = cmplt_cnt;
    int nexp = 0;
    int k;
    logic [15:0] ef;
    @(negedge clk); chnl_mask = m; strt_cnv = 1'b1;
    @(negedge clk); strt_cnv = 1'b0; chnl_mask = ~m;
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    strt_cnv = 1'b1;
    @(negedge clk); strt_cnv = 1'b0;
    wait_cmplt(cbase + 1, 20000, tag);
    repeat (4) @(negedge clk);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_ncmplt"}, 32'(cmplt_cnt - cbase), 32'd1);
    for (int c = 0; c < NUM_CHNNL; c++) if (m[c]) begin model_store(c, adc_val[c]); nexp += 2; end
    chk({tag, "_nframes"}, 32'(frames.size() - fbase), 32'(nexp));
    k = fbase;
    for (int c = 0; c < NUM_CHNNL; c++) begin
      if (m[c]) begin
        for (int r = 0; r < 2; r++) begin
          ef = {2'b00, 3'(c), 11'h000};
          if (k < frames.size()) begin
            chk({tag, "_mosi"}, 32'(frames[k]), 32'(ef));
            chk({tag, "_sslow"}, 32'(low_lens[k]), 32'(FRAME_CLKS));
            chk({tag, "_falls"}, 32'(fall_list[k]), 32'd16);
            if (r == 1) chk({tag, "_gap"}, 32'(gaps[k]), 32'd2);
          end
          k++;
        end
      end
    end
    check_rd_all({tag, "_rd"});
  endtask

  initial begin
    int fbase, cbase, n;
    logic [RES_W-1:0] v;
    rst = 1'b1; strt_cnv = 1'b0; cont = 1'b0; chnl_mask = 8'h00; rd_chnl = 3'd0;
    for (int c = 0; c < NUM_CHNNL; c++) adc_val[c] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("rst_ssn", 32'(a2d_SS_n), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_rd_all("rst_rd");

    // Directed single pass on channels 0 and 2
    adc_val[0] = 12'hA5C; adc_val[2] = 12'h3F1;
    do_pass(8'h05, "pass05");
    rd_chnl = 3'd0; #1; chk("pass05_ch0", 32'(rd_data), 32'hA5C);
    rd_chnl = 3'd2; #1; chk("pass05_ch2", 32'(rd_data), 32'h3F1);

    // Empty mask: no SPI traffic, completion one cycle later
    fbase = frames.size();
    @(negedge clk); chnl_mask = 8'h00; strt_cnv = 1'b1;
    @(negedge clk); strt_cnv = 1'b0;
    chk("mask0_cmplt_hi", 32'(cnv_cmplt), 32'd1);
    chk("mask0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("mask0_cmplt_lo", 32'(cnv_cmplt), 32'd0);
    repeat (50) @(negedge clk);
    chk("mask0_noframes", 32'(frames.size() - fbase), 32'd0);
    chk("mask0_ssn", 32'(a2d_SS_n), 32'd1);

    // Randomized single passes
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < NUM_CHNNL; c++) adc_val[c] = RES_W'($urandom);
      do_pass(8'($urandom_range(1, 255)), "rand");
    end

    // Continuous scan of channel 7, then drop cont
    fbase = frames.size(); cbase = cmplt_cnt;
    cont = 1'b1;
    adc_val[7] = RES_W'($urandom);
    @(negedge clk); chnl_mask = 8'h80; strt_cnv = 1'b1;
    @(negedge clk); strt_cnv = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      v = adc_val[7];
      wait_cmplt(cbase + p, 5000, "cont");
      model_store(7, v);
      adc_val[7] = RES_W'($urandom);
      rd_chnl = 3'd7; #1;
      chk("cont_rd7", 32'(rd_data), 32'(exp_res[7]));
      if (p == 2) cont = 1'b0;
      if (p < 3) chk("cont_busy", 32'(busy), 32'd1);
    end
    repeat (3000) @(negedge clk);
    chk("cont_busy_end", 32'(busy), 32'd0);
    chk("cont_ncmplt", 32'(cmplt_cnt - cbase), 32'd3);
    chk("cont_nframes", 32'(frames.size() - fbase), 32'd6);

    // Reset during the 8th bit of a READ frame
    fbase = frames.size();
    adc_val[3] = RES_W'($urandom);
    @(negedge clk); chnl_mask = 8'h08; strt_cnv = 1'b1;
    @(negedge clk); strt_cnv = 1'b0;
    n = 0;
    while (!((frames.size() == fbase + 1) && !a2d_SS_n && (fall_cnt == 8) && (bitcnt == 7)) && (n < 5000)) begin
      @(negedge clk); n++;
    end
    chk("rstmid_reach", 32'(n < 5000), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ssn", 32'(a2d_SS_n), 32'd1);
    chk("rstmid_sclk", 32'(SCLK), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_rd_all("rstmid_rd");

    // Averaging on channel 1: 0x400 then 0x800
    adc_val[1] = 12'h400;
    do_pass(8'h02, "avg1");
    rd_chnl = 3'd1; #1; chk("avg_first", 32'(rd_data), 32'h400);
    adc_val[1] = 12'h800;
    do_pass(8'h02, "avg2");
    rd_chnl = 3'd1; #1; chk("avg_second", 32'(rd_data), 32'(AVG_SECOND));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
